// File: rtl/microwave_timer_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Cook-timer sequencer for a microwave. Keypad digits are shifted into a
// three-digit BCD time (min : sec_tens sec_ones). Once started, the time counts
// down by one second every CLK_PER_SEC clocks while the magnetron is enabled.
// Start/stop/clear strobes and the door interlock move the controller between
// IDLE, RUNNING, PAUSED and DONE.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   digit_valid in   one-cycle strobe qualifying digit
//   digit[3:0]  in   keypad digit, binary 0-9 (10-15 are rejected)
//   start       in   one-cycle start/resume strobe
//   stop        in   one-cycle pause/cancel strobe
//   clear       in   one-cycle clear strobe
//   door_closed in   level, 1 = door closed
//   sec_ones    out  BCD seconds units (0-9)
//   sec_tens    out  BCD seconds tens (0-5)
//   min         out  BCD minutes (0-9)
//   mag_on      out  magnetron enable (state == RUNNING)
//   done        out  cook complete (state == DONE)
//   state[1:0]  out  00 IDLE, 01 RUNNING, 10 PAUSED, 11 DONE
//
// Same-cycle strobe priority: clear > stop > door open > start > digit_valid.
// An event that has no effect in the current state does not mask the events
// below it.
// -----------------------------------------------------------------------------
module microwave_timer_ctrl #(
  parameter int CLK_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_PAUSED  = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    min_q, min_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;

  // One-second BCD decrement of the current time. Only used while RUNNING,
  // where the time is never 0:00, so the minute borrow cannot underflow.
  logic [3:0] dec_min, dec_tens, dec_ones;
  logic       dec_zero;
  logic       time_zero;

  always_comb begin
    dec_min  = min_q;
    dec_tens = tens_q;
    dec_ones = ones_q;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_q != 4'd0) begin
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_q - 4'd1;
      end
    end
  end

  assign dec_zero  = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
  assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      min_q   <= 4'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          min_d  = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
        end else if (start && door_closed && !time_zero) begin
          state_d = S_RUNNING;
          presc_d = '0;
        end else if (digit_valid && (digit <= 4'd9) && (ones_q <= 4'd5)) begin
          // Shift left; ones above 5 would become an illegal tens digit.
          min_d  = tens_q;
          tens_d = ones_q;
          ones_d = digit;
        end
      end

      S_RUNNING: begin
        if (clear) begin
          state_d = S_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          presc_d = '0;
        end else if (stop || !door_closed) begin
          // Pause wins over a coincident terminal count; prescaler is held.
          state_d = S_PAUSED;
        end else if (presc_q == PRESC_TERM) begin
          presc_d = '0;
          min_d   = dec_min;
          tens_d  = dec_tens;
          ones_d  = dec_ones;
          if (dec_zero) begin
            state_d = S_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      S_PAUSED: begin
        if (clear || stop) begin
          state_d = S_IDLE;
          min_d   = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          presc_d = '0;
        end else if (start && door_closed) begin
          state_d = S_RUNNING;
        end
      end

      S_DONE: begin
        if (clear || stop) begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign min      = min_q;
  assign state    = state_q;
  assign mag_on   = (state_q == S_RUNNING);
  assign done     = (state_q == S_DONE);

endmodule
